regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's fixed 7-GPR + IR register file.
- Provides NUM_GPR general-purpose registers of DATA_W bits, each gated by a write enable.
- Provides two combinational read ports, a dedicated instruction-register load path, and a per-register busy scoreboard.
- Sits between the decode/control FSM (reserve, IR load) and the ALU/memory writeback path (write port).

Parameters:
- DATA_W, 16, width of every GPR and of the IR.
- NUM_GPR, 7, number of general-purpose registers; legal range 2..64.
- AW, $clog2(NUM_GPR), register address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- we  in  1  writeback enable.
- waddr  in  AW  writeback register index.
- wdata  in  DATA_W  writeback data.
- ra_addr  in  AW  read port A index.
- ra_data  out  DATA_W  read port A data.
- ra_busy  out  1  port A register has a pending write.
- rb_addr  in  AW  read port B index.
- rb_data  out  DATA_W  read port B data.
- rb_busy  out  1  port B register has a pending write.
- rsv  in  1  reserve (mark busy) the register at rsv_addr.
- rsv_addr  in  AW  register to reserve.
- ir_load  in  1  load the IR.
- ir_data  in  DATA_W  instruction word.
- ir  out  DATA_W  current instruction.
- busy  out  NUM_GPR  scoreboard vector; bit i set means GPR i is pending.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (async assert, sync-to-clk deassert by system): all GPRs = 0, ir = 0, busy = 0, sb_err = 0.
- Write: on posedge clk with we=1 and waddr < NUM_GPR, gpr[waddr] <= wdata. we=0 means no write; waddr is then ignored, which fixes the unconditional-write behaviour of the previous generation.
- Out-of-range index (>= NUM_GPR, only possible when NUM_GPR is not a power of 2):
  - Writes are dropped.
  - Reads return 0 with busy = 0.
  - A reserve is dropped and sets sb_err.
- Reads: combinational from the current register state; zero latency.
- A write in cycle N is visible on ra_data/rb_data in cycle N+1. Bypass changes this; see Optional Feature.
- IR: ir <= ir_data on posedge clk when ir_load=1, otherwise it holds. The IR is independent of the GPR write port, and both may update in the same cycle.
- Scoreboard, per GPR i, evaluated each posedge:
  - rsv && rsv_addr==i: busy[i] <= 1. This has priority over a clear in the same cycle, so the new producer wins.
  - else we && waddr==i: busy[i] <= 0.
  - else: hold.
- Writes to a non-busy register are permitted; data is written, busy stays 0, and no error is raised.
- Reserving an already-busy register, with no same-cycle clear of that register, sets sb_err; busy stays 1.
- sb_err is cleared only by reset.
- ra_busy = busy[ra_addr] and rb_busy = busy[rb_addr], both combinational.
- Reset mid-operation: all pending reservations are discarded and busy returns to 0 immediately.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If we=1 and waddr==ra_addr (in range), ra_data = wdata in the same cycle.
  - ra_busy = 0 for that register, unless rsv to the same register occurs in the same cycle.
  - Port B behaves identically.
- Undefined: reads return only registered state; forwarding logic is absent.

Decomposition:
- Package regfile_pkg:
  - DATA_W_DEF = 16.
  - NUM_GPR_DEF = 7.
  - typedef logic [DATA_W_DEF-1:0] word_t.
  - function in_range(idx, n) for index checking.
- Sub-module regfile_scoreboard:
  - Holds the busy vector, set/clear priority and sb_err generation.
  - Parametrised by NUM_GPR/AW.
  - Instantiated once.
- The data array and read muxes stay in regfile_sb.

Test Plan:
1. Reset: assert rst_n=0 mid-write (we=1, waddr=2, wdata=16'hBEEF) -> after release, all reads = 0, ir = 0, busy = 0, sb_err = 0.
2. Gated write: we=0, waddr=3, wdata=16'h1234, then we=1, waddr=3, wdata=16'h5678 -> gpr3 reads 0 after the first edge and 16'h5678 after the second.
3. Scoreboard: rsv to reg 4 -> busy[4]=1 next cycle. Then in one cycle, we=1 to reg 4 with rsv to reg 4 -> busy[4] stays 1 and sb_err stays 0. Then write reg 4 only -> busy[4]=0.
4. Error: rsv to reg 1 twice in consecutive cycles with no write -> sb_err=1 and stays 1 until reset.
5. IR and GPR same cycle: ir_load=1, ir_data=16'hA5A5 with we=1, waddr=0, wdata=16'h0F0F -> ir = 16'hA5A5 and gpr0 = 16'h0F0F.
6. Bypass (REGFILE_BYPASS_EN): reg 5 busy, we=1, waddr=5, wdata=16'hCAFE, ra_addr=5 -> same cycle ra_data = 16'hCAFE, ra_busy = 0. Without the macro, ra_data shows the old value and ra_busy = 1 that cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and index-checking helper for the regfile_sb register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned NUM_GPR_DEF = 7;

   typedef logic [DATA_W_DEF-1:0] word_t;

   // Indices at or above n only occur when the GPR count is not a power of two.
   function automatic logic in_range(input int unsigned idx, input int unsigned n);
      return idx < n;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-GPR busy scoreboard: reserve sets, writeback clears (reserve wins),
// and a sticky error for double-reserve or out-of-range reserve.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_GPR = NUM_GPR_DEF,
   parameter int unsigned AW      = $clog2(NUM_GPR)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic               rsv,
   input  logic [AW-1:0]      rsv_addr,
   output logic [NUM_GPR-1:0] busy,
   output logic               sb_err
);

   logic [NUM_GPR-1:0] r_busy;
   logic               r_sb_err;
   logic [NUM_GPR-1:0] w_set;
   logic [NUM_GPR-1:0] w_clr;
   logic               w_err;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int i = 0; i < int'(NUM_GPR); i++) begin
         w_set[i] = rsv && (rsv_addr == AW'(i));
         w_clr[i] = we  && (waddr    == AW'(i));
      end
      w_err = rsv && (!in_range(32'(rsv_addr), NUM_GPR) || (|(w_set & r_busy & ~w_clr)));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= '0;
         r_sb_err <= 1'b0;
      end else begin
         r_busy   <= w_set | (r_busy & ~w_clr);
         r_sb_err <= r_sb_err | w_err;
      end
   end

   assign busy   = r_busy;
   assign sb_err = r_sb_err;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised GPR file with IR, two combinational read ports and busy scoreboard.
// Optional same-cycle write forwarding to the read ports: define REGFILE_BYPASS_EN.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned DATA_W  = DATA_W_DEF,
   parameter  int unsigned NUM_GPR = NUM_GPR_DEF,
   localparam int unsigned AW      = $clog2(NUM_GPR)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [AW-1:0]      ra_addr,
   output logic [DATA_W-1:0]  ra_data,
   output logic               ra_busy,
   input  logic [AW-1:0]      rb_addr,
   output logic [DATA_W-1:0]  rb_data,
   output logic               rb_busy,
   input  logic               rsv,
   input  logic [AW-1:0]      rsv_addr,
   input  logic               ir_load,
   input  logic [DATA_W-1:0]  ir_data,
   output logic [DATA_W-1:0]  ir,
   output logic [NUM_GPR-1:0] busy,
   output logic               sb_err
);

   logic [DATA_W-1:0]  r_gpr [NUM_GPR];
   logic [DATA_W-1:0]  r_ir;
   logic [NUM_GPR-1:0] w_busy;

   regfile_scoreboard #(
      .NUM_GPR (NUM_GPR),
      .AW      (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .rsv      (rsv),
      .rsv_addr (rsv_addr),
      .busy     (w_busy),
      .sb_err   (sb_err)
   );

   // NOTE: the array is reset because software relies on GPRs reading zero after reset; this keeps it in flops, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_GPR); i++) r_gpr[i] <= '0;
      end else if (we && in_range(32'(waddr), NUM_GPR)) begin
         r_gpr[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_ir <= '0;
      else if (ir_load) r_ir <= ir_data;
   end

   always_comb begin
      ra_data = '0;
      ra_busy = 1'b0;
      if (in_range(32'(ra_addr), NUM_GPR)) begin
         ra_data = r_gpr[ra_addr];
         ra_busy = w_busy[ra_addr];
`ifdef REGFILE_BYPASS_EN
         if (we && (waddr == ra_addr)) begin
            ra_data = wdata;
            ra_busy = rsv && (rsv_addr == ra_addr);
         end
`endif
      end
   end

   always_comb begin
      rb_data = '0;
      rb_busy = 1'b0;
      if (in_range(32'(rb_addr), NUM_GPR)) begin
         rb_data = r_gpr[rb_addr];
         rb_busy = w_busy[rb_addr];
`ifdef REGFILE_BYPASS_EN
         if (we && (waddr == rb_addr)) begin
            rb_data = wdata;
            rb_busy = rsv && (rsv_addr == rb_addr);
         end
`endif
      end
   end

   assign ir   = r_ir;
   assign busy = w_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default 16-bit x 7 GPR configuration).
module tb_regfile_sb;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [2:0]  waddr;
   word_t       wdata;
   logic [2:0]  ra_addr;
   word_t       ra_data;
   logic        ra_busy;
   logic [2:0]  rb_addr;
   word_t       rb_data;
   logic        rb_busy;
   logic        rsv;
   logic [2:0]  rsv_addr;
   logic        ir_load;
   word_t       ir_data;
   word_t       ir;
   logic [6:0]  busy;
   logic        sb_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .ra_busy  (ra_busy),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .rb_busy  (rb_busy),
      .rsv      (rsv),
      .rsv_addr (rsv_addr),
      .ir_load  (ir_load),
      .ir_data  (ir_data),
      .ir       (ir),
      .busy     (busy),
      .sb_err   (sb_err)
   );

   typedef struct {
      logic       we;
      logic [2:0] waddr;
      word_t      wdata;
      logic       rsv;
      logic [2:0] rsv_addr;
      logic       ir_load;
      word_t      ir_data;
      logic [2:0] ra_addr;
      logic [2:0] rb_addr;
      word_t      exp_ra;
      logic       exp_ra_busy;
      word_t      exp_rb;
      logic       exp_rb_busy;
      word_t      exp_ir;
      logic [6:0] exp_busy;
      logic       exp_err;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock edge, then the one-shot controls drop so later reads show registered state.
   task automatic tick();
      @(posedge clk);
      #1;
      we      = 1'b0;
      rsv     = 1'b0;
      ir_load = 1'b0;
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //         we waddr wdata     rsv ra  irl ir_data   ra rb  exp_ra    rab exp_rb    rbb exp_ir    busy        err
      vecs[0]  = '{0, 3, 16'h1234, 0, 0, 0, 16'h0000, 3, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 7'b0000000, 0};
      vecs[1]  = '{1, 3, 16'h5678, 0, 0, 0, 16'h0000, 3, 3, 16'h5678, 0, 16'h5678, 0, 16'h0000, 7'b0000000, 0};
      vecs[2]  = '{0, 0, 16'h0000, 1, 4, 0, 16'h0000, 4, 3, 16'h0000, 1, 16'h5678, 0, 16'h0000, 7'b0010000, 0};
      vecs[3]  = '{1, 4, 16'h4444, 1, 4, 0, 16'h0000, 4, 4, 16'h4444, 1, 16'h4444, 1, 16'h0000, 7'b0010000, 0};
      vecs[4]  = '{1, 4, 16'h4445, 0, 0, 0, 16'h0000, 4, 4, 16'h4445, 0, 16'h4445, 0, 16'h0000, 7'b0000000, 0};
      vecs[5]  = '{1, 0, 16'h0F0F, 0, 0, 1, 16'hA5A5, 0, 3, 16'h0F0F, 0, 16'h5678, 0, 16'hA5A5, 7'b0000000, 0};
      vecs[6]  = '{1, 6, 16'h6666, 0, 0, 0, 16'h0000, 6, 6, 16'h6666, 0, 16'h6666, 0, 16'hA5A5, 7'b0000000, 0};
      vecs[7]  = '{1, 7, 16'hDEAD, 0, 0, 0, 16'hFFFF, 7, 6, 16'h0000, 0, 16'h6666, 0, 16'hA5A5, 7'b0000000, 0};
      vecs[8]  = '{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0F0F, 0, 16'h0000, 0, 16'hA5A5, 7'b0000000, 0};
      vecs[9]  = '{1, 5, 16'h5555, 1, 2, 0, 16'h0000, 2, 5, 16'h0000, 1, 16'h5555, 0, 16'hA5A5, 7'b0000100, 0};
      vecs[10] = '{0, 0, 16'h0000, 1, 5, 0, 16'h0000, 5, 2, 16'h5555, 1, 16'h0000, 1, 16'hA5A5, 7'b0100100, 0};

      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra_addr = '0; rb_addr = '0;
      rsv = 1'b0; rsv_addr = '0; ir_load = 1'b0; ir_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;

      // Reset asserted in the middle of a write, with a reservation pending.
      we = 1'b1; waddr = 3'd1; wdata = 16'h1111; rsv = 1'b1; rsv_addr = 3'd6;
      tick();
      ra_addr = 3'd1;
      #1;
      check("pre_reset gpr1", 32'(ra_data), 32'h1111);
      check("pre_reset busy", 32'(busy), 32'h40);
      we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1; we = 1'b0;
      #1;
      for (int r = 0; r < 7; r++) begin
         ra_addr = 3'(r); rb_addr = 3'(r);
         #1;
         check($sformatf("reset gpr%0d port A", r), 32'(ra_data), 32'h0);
         check($sformatf("reset gpr%0d port B", r), 32'(rb_data), 32'h0);
      end
      check("reset ir", 32'(ir), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset sb_err", 32'(sb_err), 32'h0);

      for (int i = 0; i < 11; i++) begin
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         rsv = vecs[i].rsv; rsv_addr = vecs[i].rsv_addr;
         ir_load = vecs[i].ir_load; ir_data = vecs[i].ir_data;
         ra_addr = vecs[i].ra_addr; rb_addr = vecs[i].rb_addr;
         tick();
         check($sformatf("v%0d ra_data", i), 32'(ra_data), 32'(vecs[i].exp_ra));
         check($sformatf("v%0d ra_busy", i), 32'(ra_busy), 32'(vecs[i].exp_ra_busy));
         check($sformatf("v%0d rb_data", i), 32'(rb_data), 32'(vecs[i].exp_rb));
         check($sformatf("v%0d rb_busy", i), 32'(rb_busy), 32'(vecs[i].exp_rb_busy));
         check($sformatf("v%0d ir", i), 32'(ir), 32'(vecs[i].exp_ir));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("v%0d sb_err", i), 32'(sb_err), 32'(vecs[i].exp_err));
      end

      // Same-cycle view of a write to busy reg 5 (holds 16'h5555).
      we = 1'b1; waddr = 3'd5; wdata = 16'hCAFE; ra_addr = 3'd5; rb_addr = 3'd5;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("same-cycle ra_data", 32'(ra_data), 32'hCAFE);
      check("same-cycle ra_busy", 32'(ra_busy), 32'h0);
      check("same-cycle rb_data", 32'(rb_data), 32'hCAFE);
`else
      check("same-cycle ra_data", 32'(ra_data), 32'h5555);
      check("same-cycle ra_busy", 32'(ra_busy), 32'h1);
      check("same-cycle rb_data", 32'(rb_data), 32'h5555);
`endif
      tick();
      check("after write ra_data", 32'(ra_data), 32'hCAFE);
      check("after write ra_busy", 32'(ra_busy), 32'h0);
      check("after write busy", 32'(busy), 32'h04);

      // Double reserve of reg 1 with no intervening write.
      rsv = 1'b1; rsv_addr = 3'd1;
      tick();
      check("first rsv busy", 32'(busy), 32'h06);
      check("first rsv sb_err", 32'(sb_err), 32'h0);
      rsv = 1'b1; rsv_addr = 3'd1;
      tick();
      check("double rsv sb_err", 32'(sb_err), 32'h1);
      check("double rsv busy", 32'(busy), 32'h06);
      repeat (3) tick();
      check("sb_err sticky idle", 32'(sb_err), 32'h1);
      we = 1'b1; waddr = 3'd1; wdata = 16'h0001;
      tick();
      check("clear reg1 busy", 32'(busy), 32'h04);
      check("sb_err sticky after write", 32'(sb_err), 32'h1);

      pulse_reset();
      check("reset clears sb_err", 32'(sb_err), 32'h0);
      check("reset clears busy", 32'(busy), 32'h0);

      // Reserve of a nonexistent register is dropped but flagged.
      rsv = 1'b1; rsv_addr = 3'd7;
      tick();
      check("oob rsv sb_err", 32'(sb_err), 32'h1);
      check("oob rsv busy", 32'(busy), 32'h0);
      ra_addr = 3'd7;
      #1;
      check("oob read busy", 32'(ra_busy), 32'h0);

      pulse_reset();
      check("final reset sb_err", 32'(sb_err), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
